// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC0808 scan sequencer.
package adc_pkg;

  // Sequencer states, in scan order.
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LATCH,
    WAIT_LO,
    WAIT_HI,
    READ,
    NEXT,
    DONE
  } state_t;

  // Analog mux channel address.
  typedef logic [2:0] ch_t;

  // Default strobe lengths in clock cycles.
  localparam int SETUP_CYC_DEF = 2;
  localparam int START_CYC_DEF = 2;
  localparam int RD_CYC_DEF    = 2;

  // Largest of the cycle counts, used to size the shared down-counter.
  function automatic int max_cyc(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/adc_strobe_timer.sv
// Loadable down-counter with a zero flag. Counts down one per cycle until it
// reaches zero and then holds; a load overrides the count.
module adc_strobe_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Count register: load wins, otherwise decrement until zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/adc0808_seq.sv
// ADC0808 scan sequencer: walks NUM_CH mux channels starting at CH_BASE,
// strobes ALE/START, waits for an EOC low/high cycle, reads the result with
// OE and stores slots 0..3 in r1..r4.
// Optional feature macro: ADC_TIMEOUT_EN -- bounds the EOC wait to
// TIMEOUT_CYC cycles; on expiry the slot gets 8'hFF and err is raised.
module adc0808_seq
  import adc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_BASE     = 0,
  parameter int SETUP_CYC   = SETUP_CYC_DEF,
  parameter int START_CYC   = START_CYC_DEF,
  parameter int RD_CYC      = RD_CYC_DEF,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       eoc,
  input  logic [7:0] datain,
  output logic [2:0] add,
  output logic       ALE,
  output logic       START,
  output logic       OE,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic [7:0] r3,
  output logic [7:0] r4,
  output logic       done,
  output logic       busy,
  output logic       err
);

  // One counter serves every timed phase, so it is sized for the longest one.
  localparam int TW = $clog2(max_cyc(SETUP_CYC, START_CYC, RD_CYC, TIMEOUT_CYC) + 1);
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] START_LD = TW'(START_CYC - 1);
  localparam logic [TW-1:0] RD_LD    = TW'(RD_CYC - 1);
`ifdef ADC_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC - 1);
`endif

  state_t        state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  ch_t           add_reg;
  logic          ale_reg, oe_reg, done_reg, busy_reg;
  logic          eoc_meta_reg, eoc_sync_reg;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [7:0]    res [4];
`ifdef ADC_TIMEOUT_EN
  logic          err_set;
  logic          err_reg;
`endif

  adc_strobe_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Two-flop synchronizer for the converter's EOC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eoc_meta_reg <= 1'b0;
      eoc_sync_reg <= 1'b0;
    end else begin
      eoc_meta_reg <= eoc;
      eoc_sync_reg <= eoc_meta_reg;
    end
  end

  // Next-state logic; the timer is loaded on entry to each timed state.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    wr_en      = 1'b0;
    wr_data    = datain;
`ifdef ADC_TIMEOUT_EN
    err_set    = 1'b0;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if (init) begin
          state_next = ADDR;
          idx_next   = '0;
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LD;
        end
      end
      ADDR: begin
        if (tmr_zero) begin
          state_next = LATCH;
          tmr_load   = 1'b1;
          tmr_val    = START_LD;
        end
      end
      LATCH: begin
        if (tmr_zero) begin
          state_next = WAIT_LO;
`ifdef ADC_TIMEOUT_EN
          tmr_load   = 1'b1;
          tmr_val    = TIMEOUT_LD;
`endif
        end
      end
      WAIT_LO: begin
        if (!eoc_sync_reg) begin
          state_next = WAIT_HI;
`ifdef ADC_TIMEOUT_EN
        end else if (tmr_zero) begin
          state_next = NEXT;
          wr_en      = 1'b1;
          wr_data    = 8'hFF;
          err_set    = 1'b1;
`endif
        end
      end
      WAIT_HI: begin
        if (eoc_sync_reg) begin
          state_next = READ;
          tmr_load   = 1'b1;
          tmr_val    = RD_LD;
`ifdef ADC_TIMEOUT_EN
        end else if (tmr_zero) begin
          state_next = NEXT;
          wr_en      = 1'b1;
          wr_data    = 8'hFF;
          err_set    = 1'b1;
`endif
        end
      end
      READ: begin
        // Capture on the last OE cycle so the bus has settled.
        if (tmr_zero) begin
          state_next = NEXT;
          wr_en      = 1'b1;
        end
      end
      NEXT: begin
        if (idx_reg == 3'(NUM_CH - 1)) begin
          state_next = DONE;
        end else begin
          state_next = ADDR;
          idx_next   = idx_reg + 3'd1;
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, channel index and registered strobes derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      add_reg   <= ch_t'(CH_BASE);
      ale_reg   <= 1'b0;
      oe_reg    <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      // The mux address only moves on the way into ADDR.
      if (state_next == ADDR) add_reg <= ch_t'(CH_BASE) + idx_next;
      ale_reg   <= (state_next == LATCH);
      oe_reg    <= (state_next == READ);
      done_reg  <= (state_next == DONE);
      busy_reg  <= !(state_next inside {IDLE, DONE});
    end
  end

  // Result slots 0..3; higher slots are converted but not stored.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [7:0] slot_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_reg <= '0;
      end else if (wr_en && idx_reg == 3'(gi)) begin
        slot_reg <= wr_data;
      end
    end
    assign res[gi] = slot_reg;
  end

`ifdef ADC_TIMEOUT_EN
  // Sticky timeout flag, cleared when a new scan is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if ((state_reg inside {IDLE, DONE}) && init) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign add   = add_reg;
  assign ALE   = ale_reg;
  assign START = ale_reg;
  assign OE    = oe_reg;
  assign done  = done_reg;
  assign busy  = busy_reg;
  assign r1    = res[0];
  assign r2    = res[1];
  assign r3    = res[2];
  assign r4    = res[3];

endmodule

// File: tb/tb_adc0808_seq.sv
// Bench for adc0808_seq: instance 0 (NUM_CH=4, CH_BASE=0) and instance 1
// (NUM_CH=2, CH_BASE=6), each driven by a converter model.
module tb_adc0808_seq;

  localparam int N_DUT = 2;
`ifdef ADC_TIMEOUT_EN
  localparam int N_VEC = 5;
`else
  localparam int N_VEC = 3;
`endif

  logic       clk;
  logic       rst;
  logic       init   [N_DUT];
  logic       eoc    [N_DUT];
  logic [7:0] datain [N_DUT];
  logic [2:0] add    [N_DUT];
  logic       ALE    [N_DUT];
  logic       START  [N_DUT];
  logic       OE     [N_DUT];
  logic [7:0] r1     [N_DUT];
  logic [7:0] r2     [N_DUT];
  logic [7:0] r3     [N_DUT];
  logic [7:0] r4     [N_DUT];
  logic       done   [N_DUT];
  logic       busy   [N_DUT];
  logic       err    [N_DUT];

  logic [7:0] data_base [N_DUT];
  int         stuck_ch  [N_DUT];
  logic [2:0] add_q     [N_DUT][$];
  logic [7:0] res_q     [$];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int             dut;
    logic [7:0]     base;
    int             stuck;
    int             glitch;
    logic [3:0][7:0] exp_r;
    logic           exp_err;
  } vec_t;

  vec_t vecs [N_VEC];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int base_ch(input int d);
    return (d == 0) ? 0 : 6;
  endfunction

  function automatic logic [7:0] rsel(input int d, input int k);
    case (k)
      0:       return r1[d];
      1:       return r2[d];
      2:       return r3[d];
      default: return r4[d];
    endcase
  endfunction

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    adc0808_seq #(
      .NUM_CH      (nch(gi)),
      .CH_BASE     (base_ch(gi)),
      .TIMEOUT_CYC (50)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .init   (init[gi]),
      .eoc    (eoc[gi]),
      .datain (datain[gi]),
      .add    (add[gi]),
      .ALE    (ALE[gi]),
      .START  (START[gi]),
      .OE     (OE[gi]),
      .r1     (r1[gi]),
      .r2     (r2[gi]),
      .r3     (r3[gi]),
      .r4     (r4[gi]),
      .done   (done[gi]),
      .busy   (busy[gi]),
      .err    (err[gi])
    );

    // Converter model: EOC drops 3 cycles after START falls, returns 20 later.
    int   phase   = 0;
    int   cnt     = 0;
    logic start_q = 1'b0;
    always @(negedge clk) begin
      if (!rst) begin
        eoc[gi] = 1'b1;
        phase   = 0;
        cnt     = 0;
        start_q = 1'b0;
      end else begin
        if (start_q && !START[gi]) begin
          phase = 1;
          cnt   = 0;
        end else if (phase == 1) begin
          cnt++;
          if (cnt == 3) begin
            if (int'(add[gi]) != stuck_ch[gi]) begin
              eoc[gi] = 1'b0;
              phase   = 2;
            end else begin
              phase = 0;
            end
            cnt = 0;
          end
        end else if (phase == 2) begin
          cnt++;
          if (cnt == 20) begin
            eoc[gi] = 1'b1;
            phase   = 0;
          end
        end
        start_q = START[gi];
      end
      datain[gi] = data_base[gi] + 8'(add[gi]);
    end

    // Strobe monitor: widths, add sequence and add stability.
    logic       ale_q   = 1'b0;
    logic       oe_q    = 1'b0;
    int         ale_run = 0;
    int         oe_run  = 0;
    logic [2:0] ch_at_ale = '0;
    always @(negedge clk) begin
      if (rst) begin
        if (ALE[gi]) ale_run++;
        if (OE[gi]) oe_run++;
        if (ALE[gi] && !ale_q) begin
          check("start_with_ale", 32'(START[gi]), 32'd1);
          if (add_q[gi].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL add_seq: unexpected conversion of add %0d on dut %0d", add[gi], gi);
          end else begin
            check("add_seq", 32'(add[gi]), 32'(add_q[gi].pop_front()));
          end
          ch_at_ale = add[gi];
        end
        if (!ALE[gi] && ale_q) begin
          check("ale_width", 32'(ale_run), 32'd2);
          ale_run = 0;
        end
        if (OE[gi] && !oe_q) check("add_stable", 32'(add[gi]), 32'(ch_at_ale));
        if (!OE[gi] && oe_q) begin
          check("oe_width", 32'(oe_run), 32'd2);
          oe_run = 0;
        end
      end else begin
        ale_run = 0;
        oe_run  = 0;
      end
      ale_q = ALE[gi];
      oe_q  = OE[gi];
    end
  end

  task automatic pulse_init(input int d);
    @(negedge clk);
    init[d] = 1'b1;
    @(negedge clk);
    init[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int glitch, output bit ok);
    bit glitched = 1'b0;
    bit init_hi  = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (init_hi) begin
        init[d] = 1'b0;
        init_hi = 1'b0;
      end
      if (done[d]) begin
        ok = 1'b1;
        break;
      end
      if (!glitched && glitch >= 0 && int'(add[d]) == glitch && ALE[d]) begin
        init[d]  = 1'b1;
        init_hi  = 1'b1;
        glitched = 1'b1;
      end
    end
    init[d] = 1'b0;
  endtask

  task automatic check_reset_state(input int d);
    check("rst_add",   32'(add[d]),   32'(base_ch(d)));
    check("rst_ale",   32'(ALE[d]),   32'd0);
    check("rst_start", 32'(START[d]), 32'd0);
    check("rst_oe",    32'(OE[d]),    32'd0);
    check("rst_done",  32'(done[d]),  32'd0);
    check("rst_busy",  32'(busy[d]),  32'd0);
    check("rst_err",   32'(err[d]),   32'd0);
    for (int k = 0; k < 4; k++) check("rst_r", 32'(rsel(d, k)), 32'd0);
  endtask

  initial begin
    bit ok;
    int d;

    vecs[0] = '{dut: 0, base: 8'h10, stuck: -1, glitch: 2,
                exp_r: {8'h13, 8'h12, 8'h11, 8'h10}, exp_err: 1'b0};
    vecs[1] = '{dut: 0, base: 8'h20, stuck: -1, glitch: -1,
                exp_r: {8'h23, 8'h22, 8'h21, 8'h20}, exp_err: 1'b0};
    vecs[2] = '{dut: 1, base: 8'h50, stuck: -1, glitch: -1,
                exp_r: {8'h00, 8'h00, 8'h57, 8'h56}, exp_err: 1'b0};
`ifdef ADC_TIMEOUT_EN
    vecs[3] = '{dut: 0, base: 8'h30, stuck: 2, glitch: -1,
                exp_r: {8'h33, 8'hFF, 8'h31, 8'h30}, exp_err: 1'b1};
    vecs[4] = '{dut: 0, base: 8'h40, stuck: -1, glitch: -1,
                exp_r: {8'h43, 8'h42, 8'h41, 8'h40}, exp_err: 1'b0};
`endif

    rst = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      init[i]      = 1'b0;
      data_base[i] = 8'h00;
      stuck_ch[i]  = -1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) check_reset_state(i);
    rst = 1'b1;

    // Abort a scan with reset during WAIT_HI of channel 1.
    data_base[0] = 8'h10;
    for (int k = 0; k < 4; k++) add_q[0].push_back(3'(k));
    pulse_init(0);
    check("init_busy", 32'(busy[0]), 32'd1);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (add[0] == 3'd1 && eoc[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_wait_hi", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    check("r1_before_abort", 32'(r1[0]), 32'h10);
    check("busy_before_abort", 32'(busy[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_reset_state(0);
    add_q[0].delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy[0]), 32'd0);
    check("idle_done", 32'(done[0]), 32'd0);
    check("idle_ale",  32'(ALE[0]),  32'd0);
    check("idle_add",  32'(add[0]),  32'd0);

    // Table-driven scans.
    for (int v = 0; v < N_VEC; v++) begin
      d = vecs[v].dut;
      data_base[d] = vecs[v].base;
      stuck_ch[d]  = vecs[v].stuck;
      for (int k = 0; k < nch(d); k++) add_q[d].push_back(3'(base_ch(d) + k));
      for (int k = 0; k < 4; k++) res_q.push_back(vecs[v].exp_r[k]);
      pulse_init(d);
      check("start_busy", 32'(busy[d]), 32'd1);
      check("start_done", 32'(done[d]), 32'd0);
      wait_done(d, vecs[v].glitch, ok);
      check("done_seen", 32'(ok), 32'd1);
      @(negedge clk);
      for (int k = 0; k < 4; k++) check("result", 32'(rsel(d, k)), 32'(res_q.pop_front()));
      check("end_done", 32'(done[d]), 32'd1);
      check("end_busy", 32'(busy[d]), 32'd0);
      check("end_err",  32'(err[d]),  32'(vecs[v].exp_err));
      check("all_channels", 32'(add_q[d].size()), 32'd0);
      add_q[d].delete();
      $display("scan %0d dut %0d base %02h: r1..r4 = %02h %02h %02h %02h err %0d",
               v, d, vecs[v].base, r1[d], r2[d], r3[d], r4[d], err[d]);
      stuck_ch[d] = -1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
